uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Configurable UART transmitter. Serializes one byte per frame onto TX: start bit, 5–8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from an internal 8x-oversampling baud tick derived from the system clock SCLK. BMODE selects the baud rate.
- Sits between a host or register interface and the serial pin. The host starts a frame with TX_EN and gets a TX_DONE pulse when the frame completes.

Parameters:
- CLK_HZ, 100_000_000, SCLK frequency in Hz.
- OVS, 8, baud ticks per bit (oversampling factor).

Ports:
- SCLK  in  1  system clock; all logic on the rising edge.
- SCLR  in  1  reset, synchronous, active-low.
- TX_DATA  in  8  byte to send; captured at frame start.
- TX_EN  in  1  transmit request; a rising edge starts a frame.
- UMODE  in  3  [2:1] data bits (00=5, 01=6, 10=7, 11=8); [0] parity enable.
- SMODE  in  2  [0] stop bits (0=1, 1=2); [1] parity sense (0=even, 1=odd).
- BMODE  in  5  one-hot baud select: bit0=1200, bit1=2400, bit2=4800, bit3=9600, bit4=19200.
- TX  out  1  serial line; idles high.
- TX_DONE  out  1  one-SCLK pulse at frame end.

Behaviour:
- Reset: SCLR low at a rising edge of SCLK clears everything. Reset values: TX=1, TX_DONE=0, state IDLE, tick counter 0, bit counter 0, TX_EN edge detector register 0.
- Reset mid-frame aborts the frame immediately. No TX_DONE is produced for an aborted frame.
- Baud divisor: DIV = CLK_HZ/(OVS*baud), rounded to nearest. At 100 MHz this gives 10417, 5208, 2604, 1302 and 651.
  - Any BMODE value that is not one-hot selects 9600.
  - The divisor counter produces a one-cycle tick every DIV clocks.
  - The counter runs only when the state is not IDLE, and it restarts at 0 on frame start.
  - Every bit therefore lasts exactly OVS*DIV clocks; at 9600 baud that is 10416 clocks.
- Start condition: TX_EN is registered, and a rising edge (previous 0, current 1) seen in IDLE starts a frame.
  - On start, latch TX_DATA, UMODE, SMODE and the divisor. Changes to these inputs mid-frame are ignored.
  - TX_EN held high does not retrigger.
  - A rising edge of TX_EN while a frame is in progress is ignored; it is not queued.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> DONE -> IDLE.
  - IDLE: TX=1.
  - START: TX=0 for one bit time. TX goes low on the clock after the edge is detected.
  - DATA: transmit latched bits [0..N-1], LSB first, one bit time each. N = 5 + UMODE[2:1].
  - PARITY: entered only if UMODE[0]=1. TX = XOR of the N data bits, XORed with SMODE[1].
  - STOP: TX=1 for 1 or 2 bit times, per SMODE[0].
  - DONE: TX_DONE=1 for exactly one cycle, TX=1, then IDLE. A new frame may start on the next cycle.
- Bit boundaries: advance bits on the OVS-th tick, using a 3-bit sub-bit counter. The bit counter is sized for 8 data bits and 2 stop bits.
- TX is driven from a register, so there are no combinational glitches on the pin.
- Frame length in clocks: (1 + N + P + S) * OVS * DIV, where P is 1 if parity is enabled (else 0) and S is the number of stop bits. TX_DONE asserts on the cycle after the final stop bit ends.

Optional Feature:
- Macro UART_TX_BUSY_OUT_EN.
- When defined: adds output TX_BUSY (1 bit), registered. It is 1 from the cycle TX goes low for the start bit through the DONE cycle inclusive, and 0 in IDLE and under reset.
- When undefined: no TX_BUSY port and no extra logic; all other behaviour is identical.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - baud rate constants (1200, 2400, 4800, 9600, 19200);
  - the UMODE and SMODE field positions;
  - a function computing DIV from CLK_HZ, OVS and baud.
- Sub-module uart_baud_gen: inputs are clock, reset, enable/restart and the divisor; output is a one-cycle tick. The rest of uart_tx is the FSM plus the shifter.

Test Plan:
- Reset: hold SCLR=0 for 20 cycles with TX_EN toggling -> TX=1, TX_DONE=0 throughout.
- 8N1 at 9600: UMODE=110, SMODE=00, BMODE=01000, TX_DATA=8'hA1, pulse TX_EN high for 2 bit times.
  - TX sequence: 0, then 1,0,0,0,0,1,0,1, then 1, each held 10416 clocks.
  - TX_DONE is a single-cycle pulse 104160 clocks after TX falls.
  - No second frame follows.
- Parity and stop bits: UMODE=111 with SMODE=10 (odd parity), then SMODE=00 (even parity), data 8'hA1 (three 1s).
  - Odd parity: parity bit 0. Even parity: parity bit 1.
  - With SMODE[0]=1 the stop phase lasts 2 bit times and TX_DONE is delayed by one bit time.
- Width and baud: UMODE=000 (5 bits), BMODE=00100 (4800), data 8'hFF -> only 5 data bits are sent, each 20832 clocks.
  - BMODE=00011 (not one-hot) -> 10416 clocks per bit.
- Mid-frame events:
  - Change TX_DATA and re-pulse TX_EN during DATA -> the frame is unchanged and no extra frame is sent.
  - Assert SCLR=0 during DATA -> TX=1 on the next clock and TX_DONE is never asserted.
- Back-to-back: raise TX_EN on the cycle after TX_DONE -> a new start bit begins with no extra idle bit time.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, baud constants, mode field positions and divisor helper for uart_tx
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } tx_state_e;

    localparam int BAUD_1200  = 1200;
    localparam int BAUD_2400  = 2400;
    localparam int BAUD_4800  = 4800;
    localparam int BAUD_9600  = 9600;
    localparam int BAUD_19200 = 19200;

    localparam int UMODE_PAR_EN  = 0;
    localparam int UMODE_LEN_LSB = 1;
    localparam int UMODE_LEN_MSB = 2;
    localparam int SMODE_STOP2   = 0;
    localparam int SMODE_ODD     = 1;

    localparam int DIV_W = 16;

    // Rounded-to-nearest SCLK cycles per oversampling tick.
    function automatic logic [DIV_W-1:0] calc_div(input longint clk_hz, input longint ovs,
                                                  input longint baud);
        return DIV_W'((clk_hz + (ovs * baud) / 2) / (ovs * baud));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - divisor counter producing a one-cycle oversampling tick every div clocks
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == div - DIV_W'(1));
    assign tick = en && !restart && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 5-8 data bits, optional parity, 1/2 stop; UART_TX_BUSY_OUT_EN adds TX_BUSY
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int OVS    = 8
) (
    input  logic       SCLK,
    input  logic       SCLR,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    input  logic [2:0] UMODE,
    input  logic [1:0] SMODE,
    input  logic [4:0] BMODE,
    output logic       TX,
`ifdef UART_TX_BUSY_OUT_EN
    output logic       TX_BUSY,
`endif
    output logic       TX_DONE
);

    localparam logic [DIV_W-1:0] DIV_1200  = calc_div(longint'(CLK_HZ), longint'(OVS), longint'(BAUD_1200));
    localparam logic [DIV_W-1:0] DIV_2400  = calc_div(longint'(CLK_HZ), longint'(OVS), longint'(BAUD_2400));
    localparam logic [DIV_W-1:0] DIV_4800  = calc_div(longint'(CLK_HZ), longint'(OVS), longint'(BAUD_4800));
    localparam logic [DIV_W-1:0] DIV_9600  = calc_div(longint'(CLK_HZ), longint'(OVS), longint'(BAUD_9600));
    localparam logic [DIV_W-1:0] DIV_19200 = calc_div(longint'(CLK_HZ), longint'(OVS), longint'(BAUD_19200));
    localparam logic [2:0]       SUB_LAST  = 3'(OVS - 1);

    tx_state_e        state_q, state_d;
    logic             en_q;
    logic [7:0]       data_q, data_d;
    logic [2:0]       umode_q, umode_d;
    logic [1:0]       smode_q, smode_d;
    logic [DIV_W-1:0] div_q, div_d, sel_div;
    logic [2:0]       sub_q, sub_d;
    logic [2:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic start, tick, bit_end, last_data, last_stop, parity;
    logic [7:0] mask;

    always_comb begin
        unique case (BMODE)
            5'b00001: sel_div = DIV_1200;
            5'b00010: sel_div = DIV_2400;
            5'b00100: sel_div = DIV_4800;
            5'b01000: sel_div = DIV_9600;
            5'b10000: sel_div = DIV_19200;
            default:  sel_div = DIV_9600;
        endcase
    end

    assign start     = (state_q == IDLE) && TX_EN && !en_q;
    assign bit_end   = tick && (sub_q == SUB_LAST);
    assign last_data = (bit_q == ({1'b0, umode_q[UMODE_LEN_MSB:UMODE_LEN_LSB]} + 3'd4));
    assign last_stop = (bit_q == {2'b00, smode_q[SMODE_STOP2]});
    assign mask      = 8'hFF >> (2'd3 - umode_q[UMODE_LEN_MSB:UMODE_LEN_LSB]);
    assign parity    = (^(data_q & mask)) ^ smode_q[SMODE_ODD];

    uart_baud_gen u_baud (
        .clk     (SCLK),
        .resetn  (SCLR),
        .en      (state_q != IDLE),
        .restart (start),
        .div     (div_q),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        umode_d = umode_q;
        smode_d = smode_q;
        div_d   = div_q;
        sub_d   = tick ? sub_q + 3'd1 : sub_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        if (start) begin
            state_d = START;
            data_d  = TX_DATA;
            umode_d = UMODE;
            smode_d = SMODE;
            div_d   = sel_div;
            sub_d   = '0;
            bit_d   = '0;
            tx_d    = 1'b0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (bit_end) begin
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                end
                DATA: begin
                    if (!last_data) begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end else if (umode_q[UMODE_PAR_EN]) begin
                        state_d = PARITY;
                        tx_d    = parity;
                    end else begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    if (last_stop) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge SCLK) begin
        if (!SCLR) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            data_q  <= '0;
            umode_q <= '0;
            smode_q <= '0;
            div_q   <= '0;
            sub_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= TX_EN;
            data_q  <= data_d;
            umode_q <= umode_d;
            smode_q <= smode_d;
            div_q   <= div_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign TX      = tx_q;
    assign TX_DONE = done_q;
`ifdef UART_TX_BUSY_OUT_EN
    assign TX_BUSY = busy_q;
`else
    logic unused_busy;
    assign unused_busy = busy_q;
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-level reference model
module tb_uart_tx;

    localparam int CLK_HZ = 1_536_000;
    localparam int OVS    = 8;

    logic       SCLK = 1'b0;
    logic       SCLR = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_EN = 1'b0;
    logic [2:0] UMODE = 3'b110;
    logic [1:0] SMODE = 2'b00;
    logic [4:0] BMODE = 5'b01000;
    logic       TX;
    logic       TX_DONE;
`ifdef UART_TX_BUSY_OUT_EN
    logic       TX_BUSY;
`endif

    uart_tx #(.CLK_HZ(CLK_HZ), .OVS(OVS)) dut (
        .SCLK    (SCLK),
        .SCLR    (SCLR),
        .TX_DATA (TX_DATA),
        .TX_EN   (TX_EN),
        .UMODE   (UMODE),
        .SMODE   (SMODE),
        .BMODE   (BMODE),
        .TX      (TX),
`ifdef UART_TX_BUSY_OUT_EN
        .TX_BUSY (TX_BUSY),
`endif
        .TX_DONE (TX_DONE)
    );

    always #5 SCLK = ~SCLK;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int ref_bit_clocks(input logic [4:0] bm);
        int baud;
        case (bm)
            5'b00001: baud = 1200;
            5'b00010: baud = 2400;
            5'b00100: baud = 4800;
            5'b10000: baud = 19200;
            default:  baud = 9600;
        endcase
        return OVS * ((CLK_HZ + (OVS * baud) / 2) / (OVS * baud));
    endfunction

    // Expected line levels, one entry per bit time.
    task automatic build_frame(input logic [7:0] d, input logic [2:0] um, input logic [1:0] sm);
        int n, ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        n = 5 + int'(um[2:1]);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (um[0]) exp_q.push_back(((ones % 2) == 1) ^ sm[1]);
        exp_q.push_back(1'b1);
        if (sm[0]) exp_q.push_back(1'b1);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [2:0] um, input logic [1:0] sm,
                             input logic [4:0] bm, input int hold, input bit poke,
                             input int idle_after, input string tag);
        int  len, nb;
        bit  done_early, extra;
        build_frame(d, um, sm);
        len = ref_bit_clocks(bm);
        nb  = exp_q.size();
        TX_DATA = d; UMODE = um; SMODE = sm; BMODE = bm; TX_EN = 1'b1;
        @(negedge SCLK);
        check({tag, " start latency"}, 32'(TX), 32'd0);
`ifdef UART_TX_BUSY_OUT_EN
        check({tag, " busy at start"}, 32'(TX_BUSY), 32'd1);
`endif
        done_early = 1'b0;
        for (int t = 0; t < nb * len; t++) begin
            if (t > 0) @(negedge SCLK);
            if ((t % len) == 0 || (t % len) == len - 1)
                check($sformatf("%s bit%0d@%0d", tag, t / len, t % len), 32'(TX), 32'(exp_q[t / len]));
            if (TX_DONE !== 1'b0) done_early = 1'b1;
            if (t == hold) TX_EN = 1'b0;
            if (poke && t == 2 * len + 3) begin
                TX_DATA = ~d; UMODE = ~um; SMODE = ~sm; BMODE = 5'b00001; TX_EN = 1'b1;
            end
            if (poke && t == 2 * len + 9) TX_EN = 1'b0;
        end
        @(negedge SCLK);
        check({tag, " no early done"}, 32'(done_early), 32'd0);
        check({tag, " done pulse"}, 32'(TX_DONE), 32'd1);
        check({tag, " tx idle at done"}, 32'(TX), 32'd1);
`ifdef UART_TX_BUSY_OUT_EN
        check({tag, " busy at done"}, 32'(TX_BUSY), 32'd1);
`endif
        @(negedge SCLK);
        check({tag, " done single cycle"}, 32'(TX_DONE), 32'd0);
`ifdef UART_TX_BUSY_OUT_EN
        check({tag, " busy after done"}, 32'(TX_BUSY), 32'd0);
`endif
        extra = 1'b0;
        for (int t = 0; t < idle_after; t++) begin
            @(negedge SCLK);
            if (TX !== 1'b1 || TX_DONE !== 1'b0) extra = 1'b1;
        end
        if (idle_after > 0) check({tag, " no extra frame"}, 32'(extra), 32'd0);
    endtask

    initial begin
        bit bad;
        int len;
        logic [4:0] bsel [6];
        bsel = '{5'b00100, 5'b01000, 5'b10000, 5'b00011, 5'b00000, 5'b11000};

        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SCLK);
            if (TX !== 1'b1 || TX_DONE !== 1'b0) bad = 1'b1;
            TX_EN = ~TX_EN;
        end
        check("reset tx", 32'(TX), 32'd1);
        check("reset done", 32'(TX_DONE), 32'd0);
        check("reset hold", 32'(bad), 32'd0);
`ifdef UART_TX_BUSY_OUT_EN
        check("reset busy", 32'(TX_BUSY), 32'd0);
`endif
        TX_EN = 1'b0;
        @(negedge SCLK);
        SCLR = 1'b1;
        repeat (4) @(negedge SCLK);

        len = ref_bit_clocks(5'b01000);
        run_frame(8'hA1, 3'b110, 2'b00, 5'b01000, 2 * len, 1'b0, 2 * len, "8n1");
        run_frame(8'hA1, 3'b111, 2'b10, 5'b01000, 7, 1'b0, 10, "8o1");
        run_frame(8'hA1, 3'b111, 2'b00, 5'b01000, 7, 1'b0, 10, "8e1");
        run_frame(8'hA1, 3'b111, 2'b01, 5'b01000, 7, 1'b0, 10, "8e2");
        run_frame(8'hFF, 3'b000, 2'b00, 5'b00100, 3, 1'b0, 10, "5n1_4800");
        run_frame(8'h5A, 3'b110, 2'b00, 5'b00011, 3, 1'b0, 10, "bad_bmode");
        run_frame(8'h12, 3'b000, 2'b00, 5'b00001, 3, 1'b0, 10, "5n1_1200");
        run_frame(8'h3C, 3'b110, 2'b00, 5'b01000, 5, 1'b1, 3 * len, "midpoke");
        run_frame(8'hC5, 3'b101, 2'b01, 5'b10000, 2, 1'b0, 0, "b2b_a");
        run_frame(8'h69, 3'b011, 2'b10, 5'b10000, 2, 1'b0, 0, "b2b_b");
        run_frame(8'h96, 3'b110, 2'b00, 5'b10000, 2, 1'b0, 10, "b2b_c");

        TX_DATA = 8'hF0; UMODE = 3'b110; SMODE = 2'b00; BMODE = 5'b01000; TX_EN = 1'b1;
        @(negedge SCLK);
        check("abort started", 32'(TX), 32'd0);
        repeat (5) @(negedge SCLK);
        TX_EN = 1'b0;
        repeat (3 * len) @(negedge SCLK);
        SCLR = 1'b0;
        @(negedge SCLK);
        check("abort tx high", 32'(TX), 32'd1);
        check("abort no done", 32'(TX_DONE), 32'd0);
`ifdef UART_TX_BUSY_OUT_EN
        check("abort busy", 32'(TX_BUSY), 32'd0);
`endif
        repeat (3) @(negedge SCLK);
        SCLR = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10 * len; i++) begin
            @(negedge SCLK);
            if (TX !== 1'b1 || TX_DONE !== 1'b0) bad = 1'b1;
        end
        check("abort quiet", 32'(bad), 32'd0);

        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            logic [2:0] um;
            logic [1:0] sm;
            logic [4:0] bm;
            d  = 8'($urandom);
            um = 3'($urandom_range(0, 7));
            sm = 2'($urandom_range(0, 3));
            bm = bsel[$urandom_range(0, 5)];
            run_frame(d, um, sm, bm, int'($urandom_range(1, ref_bit_clocks(bm))), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? 0 : 7, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
